// File: rtl/local_inject_queue_if.sv
// Bundle between the PE, the injector slot-status lines and the local inject queue.
// The slave modport is the queue's view; the master modport is its surroundings.
interface local_inject_queue_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pe_flit;
  logic             pe_valid;
  logic             pe_ready;
  logic             north_valid;
  logic             south_valid;
  logic             east_valid;
  logic             west_valid;
  logic [WIDTH-1:0] localad;
  logic             local_valid;
  logic             inject_fire;
  logic             starve;
  logic [15:0]      inj_count;
  logic [OW-1:0]    occupancy;

  modport slave (
    input  pe_flit, pe_valid, north_valid, south_valid, east_valid, west_valid,
    output pe_ready, localad, local_valid, inject_fire, starve, inj_count, occupancy
  );

  modport master (
    output pe_flit, pe_valid, north_valid, south_valid, east_valid, west_valid,
    input  pe_ready, localad, local_valid, inject_fire, starve, inj_count, occupancy
  );
endinterface

// File: rtl/local_inject_queue.sv
// First-word-fall-through queue feeding the router injector's local input. The head
// leaves whenever any cardinal slot is free; blocked-head starvation and injections are tracked.
module local_inject_queue #(
  parameter int WIDTH        = 10,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15,
  parameter int SW           = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  local_inject_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL  = OW'(DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [SW-1:0]    sc_q, sc_d;
  logic [15:0]      inj_q, inj_d;

  logic ready;
  logic head_valid;
  logic all_busy;
  logic push;
  logic fire;

  // Handshake and fire decisions depend only on registered state and the slot lines.
  always_comb begin
    ready      = ~rst & (occ_q != FULL);
    head_valid = (occ_q != '0);
    all_busy   = bus.north_valid & bus.south_valid & bus.east_valid & bus.west_valid;
    fire       = head_valid & ~all_busy;
    push       = bus.pe_valid & ready;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    sc_d   = sc_q;
    inj_d  = inj_q;

    if (push) wptr_d = wptr_q + AW'(1);
    if (fire) begin
      rptr_d = rptr_q + AW'(1);
      inj_d  = inj_q + 16'd1;
    end

    case ({push, fire})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    // The counter only runs while a real head is being refused, and parks at the limit.
    if (fire || !head_valid) sc_d = '0;
    else if (sc_q != LIMIT)  sc_d = sc_q + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      sc_q   <= '0;
      inj_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      sc_q   <= sc_d;
      inj_q  <= inj_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.pe_flit;
  end

  assign bus.pe_ready    = ready;
  assign bus.local_valid = head_valid;
  assign bus.localad     = head_valid ? mem_q[rptr_q] : '0;
  assign bus.inject_fire = fire;
  assign bus.starve      = (sc_q == LIMIT);
  assign bus.inj_count   = inj_q;
  assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_local_inject_queue.sv
// Randomized and directed bench for local_inject_queue against a queue-based model
// of the flit stream, blocked-run length and injection total.
module tb_local_inject_queue;
  localparam int WIDTH        = 10;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 15;
  localparam int SW           = 4;

  logic clk;
  logic rst;

  local_inject_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  local_inject_queue #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .SW(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [WIDTH-1:0] model_q[$];
  int               model_run;
  int               model_inj;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_local_valid", 32'(bus.local_valid), 32'd0);
    checkOutput("rst_localad",     32'(bus.localad),     32'd0);
    checkOutput("rst_inject_fire", 32'(bus.inject_fire), 32'd0);
    checkOutput("rst_starve",      32'(bus.starve),      32'd0);
    checkOutput("rst_pe_ready",    32'(bus.pe_ready),    32'd0);
    checkOutput("rst_occupancy",   32'(bus.occupancy),   32'd0);
    checkOutput("rst_inj_count",   32'(bus.inj_count),   32'd0);
  endtask

  // One clock of stimulus; slots is {north, south, east, west}.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] f, input logic [3:0] slots);
    logic             exp_valid;
    logic             exp_ready;
    logic             exp_fire;
    logic [WIDTH-1:0] exp_ad;
    @(posedge clk);
    #1;
    bus.pe_valid    = v;
    bus.pe_flit     = f;
    bus.north_valid = slots[3];
    bus.south_valid = slots[2];
    bus.east_valid  = slots[1];
    bus.west_valid  = slots[0];
    #2;
    exp_valid = (model_q.size() != 0);
    exp_ready = (model_q.size() < DEPTH);
    exp_fire  = exp_valid && (slots != 4'hF);
    exp_ad    = exp_valid ? model_q[0] : '0;
    checkOutput("local_valid", 32'(bus.local_valid), 32'(exp_valid));
    checkOutput("localad",     32'(bus.localad),     32'(exp_ad));
    checkOutput("pe_ready",    32'(bus.pe_ready),    32'(exp_ready));
    checkOutput("inject_fire", 32'(bus.inject_fire), 32'(exp_fire));
    checkOutput("starve",      32'(bus.starve),      32'(model_run >= STARVE_LIMIT));
    checkOutput("occupancy",   32'(bus.occupancy),   32'(model_q.size()));
    checkOutput("inj_count",   32'(bus.inj_count),   32'(model_inj & 16'hFFFF));
    if (exp_fire) begin
      void'(model_q.pop_front());
      model_inj++;
    end
    if (v && exp_ready) model_q.push_back(f);
    if (exp_valid && !exp_fire) model_run++;
    else model_run = 0;
  endtask

  task automatic drainQueue();
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++)
      applyStimulus(1'b0, '0, 4'h0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.pe_valid    = 1'b0;
    bus.pe_flit     = '0;
    bus.north_valid = 1'b1;
    bus.south_valid = 1'b1;
    bus.east_valid  = 1'b1;
    bus.west_valid  = 1'b1;
    model_run       = 0;
    model_inj       = 0;

    repeat (2) @(posedge clk);
    #3;
    checkResetState();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ready_after_release", 32'(bus.pe_ready), 32'd1);

    // Idle with every slot busy.
    repeat (3) applyStimulus(1'b0, '0, 4'hF);

    // Single flit, then north frees up so it leaves at once.
    applyStimulus(1'b1, 10'b1000100101, 4'hF);
    applyStimulus(1'b0, '0, 4'b0111);
    applyStimulus(1'b0, '0, 4'hF);

    // Fill to full while blocked, offer a dropped fifth flit, then drain via east.
    applyStimulus(1'b1, 10'h005, 4'hF);
    applyStimulus(1'b1, 10'h021, 4'hF);
    applyStimulus(1'b1, 10'h027, 4'hF);
    applyStimulus(1'b1, 10'h03F, 4'hF);
    applyStimulus(1'b1, 10'h3AA, 4'hF);
    repeat (4) applyStimulus(1'b0, '0, 4'b1101);
    applyStimulus(1'b0, '0, 4'hF);

    // Hold occupancy at two with simultaneous push and fire across the pointer wrap.
    applyStimulus(1'b1, 10'h101, 4'hF);
    applyStimulus(1'b1, 10'h102, 4'hF);
    applyStimulus(1'b1, 10'h103, 4'b1110);
    applyStimulus(1'b1, 10'h104, 4'b1110);
    applyStimulus(1'b1, 10'h105, 4'b1110);
    drainQueue();

    // Starvation: one flit held for longer than the limit, then south frees.
    applyStimulus(1'b1, 10'h2C3, 4'hF);
    repeat (STARVE_LIMIT + 3) applyStimulus(1'b0, '0, 4'hF);
    applyStimulus(1'b0, '0, 4'b1011);
    applyStimulus(1'b0, '0, 4'hF);

    // Asynchronous reset with three flits queued.
    applyStimulus(1'b1, 10'h011, 4'hF);
    applyStimulus(1'b1, 10'h022, 4'hF);
    applyStimulus(1'b1, 10'h033, 4'hF);
    bus.pe_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkResetState();
    @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    checkOutput("ready_after_midrst", 32'(bus.pe_ready), 32'd1);
    model_q.delete();
    model_run = 0;
    model_inj = 0;
    repeat (3) applyStimulus(1'b0, '0, 4'h0);

    // Randomized traffic, biased towards blocked slots to exercise backpressure.
    for (int i = 0; i < 600; i++) begin
      logic             v;
      logic [WIDTH-1:0] f;
      logic [3:0]       s;
      v = ($urandom_range(0, 3) != 0);
      f = WIDTH'($urandom);
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      applyStimulus(v, f, s);
    end
    drainQueue();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/local_inject_queue.md
Name: local_inject_queue

Overview:
- Upstream neighbour of the router injector stage.
- Buffers flits from the local processing element (PE) in a small first-word-fall-through FIFO and presents the head flit on localad.
- Pops the head flit in any cycle where the injector has a free input slot, i.e. at least one of the north/south/east/west ports is empty.
- Tracks blocked-head starvation and total injections for router-level throttling and debug.

Parameters:
- WIDTH, 10: flit width in bits; matches the injector port width.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- STARVE_LIMIT, 15: blocked cycles before starve asserts; 1 to 2^SW−1.
- SW, 4: starvation counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- pe_flit  in  WIDTH  flit offered by the PE.
- pe_valid  in  1  PE flit valid.
- pe_ready  out  1  queue can accept; push = pe_valid & pe_ready.
- north_valid  in  1  north input slot occupied this cycle.
- south_valid  in  1  south input slot occupied.
- east_valid  in  1  east input slot occupied.
- west_valid  in  1  west input slot occupied.
- localad  out  WIDTH  head flit to the injector local input.
- local_valid  out  1  localad holds a real flit.
- inject_fire  out  1  head flit consumed this cycle.
- starve  out  1  head blocked for STARVE_LIMIT consecutive cycles.
- inj_count  out  16  total injections; wraps modulo 2^16.
- occupancy  out  log2(DEPTH)+1  entries held.

Behaviour:
- Reset (async, active-high; takes effect immediately, independent of clk):
  - Pointers, occupancy, starvation counter and inj_count clear to 0.
  - Storage contents need not clear.
  - Outputs during and after reset: localad=0, local_valid=0, inject_fire=0, starve=0.
  - pe_ready=0 while rst=1; pe_ready=1 in the first cycle after deassertion.
- Push: on a clk edge with pe_valid & pe_ready, write pe_flit at wptr; wptr increments, wrapping DEPTH−1 → 0.
- pe_ready = !rst & (occupancy != DEPTH). Registered state only; no combinational path from pe_valid.
- Head:
  - local_valid = (occupancy != 0).
  - localad = mem[rptr] when local_valid, else all-zero. Never drive z.
- Fire:
  - inject_fire = local_valid & ~(north_valid & south_valid & east_valid & west_valid).
  - Combinational from registered state and the slot-valid inputs.
  - On the edge with inject_fire, rptr increments with wrap.
- Latency:
  - A flit pushed into an empty queue appears on localad/local_valid in the next cycle.
  - Empty-queue bypass is forbidden.
- Simultaneous push and fire:
  - Occupancy unchanged; both pointers advance.
  - Legal at any occupancy 1..DEPTH−1.
  - At DEPTH, pe_ready=0, so only the fire occurs; no same-cycle refill.
- Ordering: strict FIFO; flits leave in push order, unmodified.
- Starvation counter (sc):
  - Clears when inject_fire or !local_valid.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - starve = (sc == STARVE_LIMIT), combinational from sc.
  - Drops in the cycle after the blocked flit fires.
- inj_count: +1 on each edge with inject_fire; 16'hFFFF → 0.
- Illegal conditions:
  - No push when full; guarded by pe_ready, and pe_valid while full is ignored.
  - No pop when empty; guarded because inject_fire requires local_valid.
- Reset mid-operation: all queued flits are discarded; nothing is emitted after rst rises.

Test Plan:
- Reset then idle (all slot valids=1, pe_valid=0) → local_valid=0, localad=10'b0, pe_ready=1, occupancy=0, inj_count=0.
- Push 10'b1000100101 into an empty queue, with north_valid=0 on the following cycle:
  - cycle+1: local_valid=1, localad=10'b1000100101, inject_fire=1.
  - cycle+2: occupancy=0, inj_count=1.
- All four slot valids=1, push 4 flits (0x005, 0x021, 0x027, 0x03F):
  - pe_ready=0 with occupancy=4; a 5th pe_valid is dropped.
  - Free east_valid → flits exit in order 0x005, 0x021, 0x027, 0x03F on consecutive cycles.
- Occupancy 2, pe_valid=1 and west_valid=0 for 3 cycles → occupancy stays 2, 3 flits out in push order, pointers wrap DEPTH−1 → 0.
- Head blocked (all valids=1) with STARVE_LIMIT=15:
  - starve=1 exactly on the 16th blocked cycle.
  - After south_valid=0 → inject_fire=1 that cycle, starve=0 the next.
- Queue holding 3 flits, assert rst asynchronously between edges → local_valid=0 and occupancy=0 immediately. After release, no stale flit appears and inj_count=0.
